// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the fetch stage.
//
// Owns the fetch address and chooses it every cycle: sequential increment,
// stall hold, branch/jump redirect, trap entry and trap return. A small
// BOOT/RUN/HALT state machine gates fetching; pc_valid qualifies pc_out.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   undefined : redirect targets have bits [1:0] cleared, mret uses epc_out
//               as-is, misaligned is tied low.
//   defined   : a misaligned redirect or mret target enters the trap vector
//               instead, saves the current pc_out in epc_out and pulses
//               misaligned for one cycle.
//
// Parameters
//   XLEN          address width in bits (at least 8)
//   RESET_VECTOR  pc_out value after reset
//   TRAP_VECTOR   trap handler entry address
//   STEP          sequential increment in bytes
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   stall           hold the current PC
//   redirect_valid  branch/jump taken, destination on redirect_target
//   trap_valid      trap accepted, faulting PC on trap_pc
//   mret            return to epc_out
//   halt_req        stop fetching after this cycle's update
//   resume          leave HALT
//   pc_out          registered fetch address
//   pc_valid        pc_out is a live fetch request
//   pc_next         value pc_out takes at the next edge (combinational)
//   epc_out         saved exception PC
//   halted          registered, high while in HALT
//   misaligned      one-cycle pulse after a rejected misaligned target
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     STEP         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc_out,
  output logic            halted,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state;
  logic [XLEN-1:0] epc_next;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_next;

  function automatic logic low_bits_set(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
`endif

  // Next-PC selection. Outside RUN everything holds, which also makes
  // pc_next equal pc_out in BOOT and HALT. Adder wraps modulo 2^XLEN.
  always_comb begin
    pc_next  = pc_out;
    epc_next = epc_out;
`ifdef PC_ALIGN_CHECK_EN
    mis_next = 1'b0;
`endif
    if (state == RUN) begin
      if (trap_valid) begin
        pc_next  = TRAP_VECTOR;
        epc_next = trap_pc;
      end else if (mret) begin
`ifdef PC_ALIGN_CHECK_EN
        if (low_bits_set(epc_out[1:0])) begin
          pc_next  = TRAP_VECTOR;
          epc_next = pc_out;
          mis_next = 1'b1;
        end else begin
          pc_next  = epc_out;
        end
`else
        pc_next = epc_out;
`endif
      end else if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
        if (low_bits_set(redirect_target[1:0])) begin
          pc_next  = TRAP_VECTOR;
          epc_next = pc_out;
          mis_next = 1'b1;
        end else begin
          pc_next  = redirect_target;
        end
`else
        pc_next = redirect_target & ALIGN_MASK;
`endif
      end else if (!stall) begin
        pc_next = pc_out + STEP_X;
      end
    end
  end

  // State register: PC/EPC take pc_next/epc_next every edge (they hold
  // outside RUN), the FSM drives pc_valid and halted as registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc_out   <= RESET_VECTOR;
      epc_out  <= '0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      pc_out  <= pc_next;
      epc_out <= epc_next;
`ifdef PC_ALIGN_CHECK_EN
      misaligned <= mis_next;
`endif
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  assign misaligned = 1'b0;
`endif

endmodule
